// File: rtl/ifetch_resp_pkg.sv
// Shared types for the instruction-fetch response path: FSM states,
// queue entry layout and the default queue depth.
package if_pkg;

  localparam int DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fsm_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } q_entry_t;

endpackage

// File: rtl/ifetch_resp_if.sv
// Fetch-side bus: PC unit request, instruction memory port and decode handshake.
// The slave view belongs to ifetch_resp; the master view is the surrounding pipeline.
interface ifetch_resp_if #(
  parameter int IMEM_AW = 30
);
  logic               pc_valid;
  logic [31:0]        pc_addr;
  logic               pc_stall;
  logic               flush;
  logic               imem_rd_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               inst_valid;
  logic               inst_ready;
  logic [31:0]        inst_data;
  logic [31:0]        inst_pc;
  logic [31:0]        inst_pc_plus_4;
  logic               addr_err;

  modport slave (
    input  pc_valid, pc_addr, flush, imem_rdata, inst_ready,
    output pc_stall, imem_rd_en, imem_addr, inst_valid, inst_data, inst_pc,
           inst_pc_plus_4, addr_err
  );

  modport master (
    output pc_valid, pc_addr, flush, imem_rdata, inst_ready,
    input  pc_stall, imem_rd_en, imem_addr, inst_valid, inst_data, inst_pc,
           inst_pc_plus_4, addr_err
  );
endinterface

// File: rtl/ifetch_resp_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs until decode takes them.
// Pointers wrap naturally because DEPTH is a power of two.
module fetch_queue
  import if_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  q_entry_t      wdata,
  output q_entry_t      rdata,
  output logic [CW-1:0] count
);

  q_entry_t          mem_q [DEPTH];
  q_entry_t          mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy; clear beats push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  // Control state is reset; entry storage only matters once count says it is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = cnt_q;

  // A net push into a full queue would overwrite the head; the stall logic upstream rules it out.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !clear && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/ifetch_resp.sv
// Instruction fetch response stage: issues single-cycle memory reads for the PC
// unit, captures returning words with their PC into a queue, and hands them to
// decode. A flush kills the queue and any read still in flight.
module ifetch_resp
  import if_pkg::*;
#(
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int IMEM_AW = 30,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst,
  ifetch_resp_if.slave bus
);

  fsm_e          state_q;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          addr_err_q, addr_err_d;

  logic          issue, push, pop, q_vld, pc_stall;
  logic [CW:0]   occ;
  logic [CW-1:0] q_cnt;
  q_entry_t      q_head, q_wdata;

  // Stall counts queued words plus the one possibly returning, so a read only
  // issues when its data is guaranteed a slot; reset forces everything quiet.
  always_comb begin
    occ           = {1'b0, q_cnt} + {{CW{1'b0}}, inflight_q};
    pc_stall      = !rst && ((occ >= (CW+1)'(DEPTH)) || (state_q == FLUSH));
    issue         = !rst && bus.pc_valid && !pc_stall && !bus.flush && (state_q != FLUSH);
    q_vld         = !rst && (q_cnt != '0);
    push          = inflight_q && !bus.flush;
    pop           = q_vld && bus.inst_ready && !bus.flush;
    q_wdata       = '{pc: inflight_pc_q, inst: bus.imem_rdata};
    inflight_d    = issue;
    inflight_pc_d = issue ? bus.pc_addr : inflight_pc_q;
    addr_err_d    = addr_err_q || (issue && (bus.pc_addr[1:0] != 2'b00));
  end

  // In-flight tracking and the sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Fetch control FSM; flush from any state lands in FLUSH for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (bus.flush) begin
      state_q <= FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (bus.pc_valid) state_q <= FETCH;
        FETCH:   if (!bus.pc_valid && !inflight_q) state_q <= IDLE;
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.flush),
    .push  (push),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_head),
    .count (q_cnt)
  );

  assign bus.pc_stall       = pc_stall;
  assign bus.imem_rd_en     = issue;
  assign bus.imem_addr      = bus.pc_addr[IMEM_AW+1:2];
  assign bus.inst_valid     = q_vld;
  assign bus.inst_data      = q_vld ? q_head.inst : '0;
  assign bus.inst_pc        = q_vld ? q_head.pc : '0;
  assign bus.inst_pc_plus_4 = q_vld ? (q_head.pc + 32'd4) : '0;
  assign bus.addr_err       = addr_err_q;

endmodule

// File: tb/tb_ifetch_resp.sv
// Directed bench for ifetch_resp: a DEPTH=4 instance shows back-to-back
// delivery, a DEPTH=2 instance covers back-pressure, flush, misalignment and reset.
module tb_ifetch_resp;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ifetch_resp_if #(.IMEM_AW(30)) b2 ();
  ifetch_resp_if #(.IMEM_AW(30)) b4 ();

  ifetch_resp #(.DEPTH(2), .IMEM_AW(30)) u_d2 (.clk(clk), .rst(rst), .bus(b2));
  ifetch_resp #(.DEPTH(4), .IMEM_AW(30)) u_d4 (.clk(clk), .rst(rst), .bus(b4));

  function automatic logic [31:0] iword(input logic [29:0] wa);
    return {wa, 2'b11} ^ 32'h5A5A_0000;
  endfunction

  // Instruction memory: word for the strobed address shows up one cycle later.
  always @(posedge clk) begin
    b2.imem_rdata <= b2.imem_rd_en ? iword(b2.imem_addr) : 32'hDEAD_BEEF;
    b4.imem_rdata <= b4.imem_rd_en ? iword(b4.imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    b2.pc_valid = 0; b2.pc_addr = 0; b2.flush = 0; b2.inst_ready = 1;
    b4.pc_valid = 0; b4.pc_addr = 0; b4.flush = 0; b4.inst_ready = 1;
    rst = 1;
    tick; tick;
    rst = 0; settle;

    // reset state
    chk("rst_valid",   b2.inst_valid, 0);
    chk("rst_rd_en",   b2.imem_rd_en, 0);
    chk("rst_stall",   b2.pc_stall, 0);
    chk("rst_data",    b2.inst_data, 0);
    chk("rst_pc",      b2.inst_pc, 0);
    chk("rst_pc4",     b2.inst_pc_plus_4, 0);
    chk("rst_aerr",    b2.addr_err, 0);
    chk("rst_valid4",  b4.inst_valid, 0);

    // back-to-back fetch 0x0,0x4,0x8 (DEPTH=4)
    tick; b4.pc_valid = 1; b4.pc_addr = 32'h0; settle;
    chk("seq_rd0",     b4.imem_rd_en, 1);
    chk("seq_addr0",   b4.imem_addr, 0);
    tick; b4.pc_addr = 32'h4; settle;
    chk("seq_lat1",    b4.inst_valid, 0);
    chk("seq_rd1",     b4.imem_rd_en, 1);
    tick; b4.pc_addr = 32'h8; settle;
    chk("seq_v0",      b4.inst_valid, 1);
    chk("seq_pc0",     b4.inst_pc, 32'h0);
    chk("seq_d0",      b4.inst_data, iword(30'h0));
    chk("seq_pc4_0",   b4.inst_pc_plus_4, 32'h4);
    chk("seq_stall",   b4.pc_stall, 0);
    tick; b4.pc_valid = 0; settle;
    chk("seq_pc1",     b4.inst_pc, 32'h4);
    chk("seq_v1",      b4.inst_valid, 1);
    tick; settle;
    chk("seq_pc2",     b4.inst_pc, 32'h8);
    chk("seq_d2",      b4.inst_data, iword(30'h2));
    tick; settle;
    chk("seq_empty",   b4.inst_valid, 0);

    // back-pressure with DEPTH=2, then release across pointer wrap
    tick; b2.inst_ready = 0; b2.pc_valid = 1; b2.pc_addr = 32'h0; settle;
    chk("bp_rd0",      b2.imem_rd_en, 1);
    chk("bp_st0",      b2.pc_stall, 0);
    tick; b2.pc_addr = 32'h4; settle;
    chk("bp_rd1",      b2.imem_rd_en, 1);
    chk("bp_st1",      b2.pc_stall, 0);
    tick; b2.pc_addr = 32'h8; settle;
    chk("bp_st2",      b2.pc_stall, 1);
    chk("bp_rd2",      b2.imem_rd_en, 0);
    tick; settle;
    chk("bp_st3",      b2.pc_stall, 1);
    chk("bp_rd3",      b2.imem_rd_en, 0);
    chk("bp_v3",       b2.inst_valid, 1);
    chk("bp_pc3",      b2.inst_pc, 32'h0);
    tick; b2.inst_ready = 1; settle;
    chk("bp_pcA",      b2.inst_pc, 32'h0);
    chk("bp_st4",      b2.pc_stall, 1);
    tick; settle;
    chk("bp_st5",      b2.pc_stall, 0);
    chk("bp_rd5",      b2.imem_rd_en, 1);
    chk("bp_addr5",    b2.imem_addr, 2);
    chk("bp_pcB",      b2.inst_pc, 32'h4);
    tick; b2.pc_valid = 0; settle;
    chk("bp_gap",      b2.inst_valid, 0);
    tick; settle;
    chk("bp_vC",       b2.inst_valid, 1);
    chk("bp_pcC",      b2.inst_pc, 32'h8);
    chk("bp_dC",       b2.inst_data, iword(30'h2));
    tick; settle;
    chk("bp_end",      b2.inst_valid, 0);

    // flush in the return cycle of the read at 0x10
    tick; b2.pc_valid = 1; b2.pc_addr = 32'h10; settle;
    chk("fl_rd0",      b2.imem_rd_en, 1);
    tick; b2.flush = 1; b2.pc_addr = 32'h40; settle;
    chk("fl_rd_kill",  b2.imem_rd_en, 0);
    chk("fl_v1",       b2.inst_valid, 0);
    tick; b2.flush = 0; settle;
    chk("fl_st",       b2.pc_stall, 1);
    chk("fl_rd2",      b2.imem_rd_en, 0);
    chk("fl_v2",       b2.inst_valid, 0);
    tick; settle;
    chk("fl_st_clr",   b2.pc_stall, 0);
    chk("fl_rd3",      b2.imem_rd_en, 1);
    chk("fl_addr3",    b2.imem_addr, 32'h10);
    tick; b2.pc_valid = 0; settle;
    chk("fl_v4",       b2.inst_valid, 0);
    tick; settle;
    chk("fl_v5",       b2.inst_valid, 1);
    chk("fl_pc5",      b2.inst_pc, 32'h40);
    chk("fl_d5",       b2.inst_data, iword(30'h10));
    tick; settle;
    chk("fl_v6",       b2.inst_valid, 0);

    // misaligned fetch sets sticky addr_err; reset with a read in flight
    tick; b2.inst_ready = 0; b2.pc_valid = 1; b2.pc_addr = 32'h6; settle;
    chk("ae_pre",      b2.addr_err, 0);
    chk("ae_rd",       b2.imem_rd_en, 1);
    chk("ae_addr",     b2.imem_addr, 1);
    tick; b2.pc_valid = 0; settle;
    chk("ae_set",      b2.addr_err, 1);
    tick; settle;
    chk("ae_hold",     b2.addr_err, 1);
    chk("ae_v",        b2.inst_valid, 1);
    chk("ae_pc",       b2.inst_pc, 32'h6);
    chk("ae_d",        b2.inst_data, iword(30'h1));
    tick; b2.pc_valid = 1; b2.pc_addr = 32'h20; settle;
    chk("ae_rd20",     b2.imem_rd_en, 1);
    tick; rst = 1; b2.pc_addr = 32'h24; settle;
    chk("rs_rd",       b2.imem_rd_en, 0);
    chk("rs_v",        b2.inst_valid, 0);
    chk("rs_st",       b2.pc_stall, 0);
    tick; rst = 0; b2.pc_valid = 0; settle;
    chk("rs_v_after",  b2.inst_valid, 0);
    chk("rs_aerr",     b2.addr_err, 0);
    chk("rs_pc",       b2.inst_pc, 0);
    tick; settle;
    chk("rs_drop",     b2.inst_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
